// File: rtl/mw_pipe_stage.sv
// M->W pipeline stage: one-cycle register with valid/ready handshake, a skid
// entry so in_ready is registered, synchronous flush and a bubble counter.
module mw_pipe_stage #(
    parameter int PAYLOAD_W = 96,
    parameter int RA_W      = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [RA_W-1:0]      in_regaddr,
    input  logic [31:0]          in_pc4,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [RA_W-1:0]      out_regaddr,
    output logic [31:0]          out_pc4,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     bubble_cnt
);
    localparam int EW     = 32 + RA_W + 32 + PAYLOAD_W;
    localparam int PC_LO  = PAYLOAD_W;
    localparam int RA_LO  = PAYLOAD_W + 32;
    localparam int INS_LO = PAYLOAD_W + 32 + RA_W;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_SKID
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   main_q, main_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic            in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic [EW-1:0]   in_entry;
    logic            in_xfer;
    logic            out_xfer;

    assign in_entry = {in_instr, in_regaddr, in_pc4, in_payload};
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        state_d = S_FULL;
                        main_d  = in_entry;
                    end
                end
                S_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        state_d = S_SKID;
                        skid_d  = in_entry;
                    end else if (out_xfer) begin
                        state_d = S_EMPTY;
                        main_d  = '0;
                    end
                end
                S_SKID: begin
                    if (out_xfer) begin
                        state_d = S_FULL;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // Registered so that out_ready never reaches in_ready combinationally.
            in_ready_q <= (state_d != S_SKID);
            if (!out_valid && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    // Bubbles must look like a null write to forwarding/hazard logic.
    assign out_instr   = out_valid ? main_q[INS_LO +: 32]  : 32'd0;
    assign out_regaddr = out_valid ? main_q[RA_LO +: RA_W] : {RA_W{1'b0}};
    assign out_pc4     = main_q[PC_LO +: 32];
    assign out_payload = main_q[PAYLOAD_W-1:0];
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_mw_pipe_stage.sv
// Directed bench for mw_pipe_stage with a randomized scoreboard pass at the end.
module tb_mw_pipe_stage;
    localparam int PAYLOAD_W = 96;
    localparam int RA_W      = 5;
    localparam int CNT_W     = 4;
    localparam int EW        = 32 + RA_W + 32 + PAYLOAD_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [RA_W-1:0]      in_regaddr;
    logic [31:0]          in_pc4;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [RA_W-1:0]      out_regaddr;
    logic [31:0]          out_pc4;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mw_pipe_stage #(.PAYLOAD_W(PAYLOAD_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_regaddr(in_regaddr), .in_pc4(in_pc4), .in_payload(in_payload),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_regaddr(out_regaddr), .out_pc4(out_pc4), .out_payload(out_payload),
        .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [RA_W-1:0] ra,
                         input logic [31:0] pc, input logic [PAYLOAD_W-1:0] pl);
        in_valid   = v;
        in_instr   = ins;
        in_regaddr = ra;
        in_pc4     = pc;
        in_payload = pl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        step();
        step();
        reset = 1'b0;
    endtask

    logic [EW-1:0] sb_q[$];
    logic [EW-1:0] exp_e;
    logic [EW-1:0] held_e;
    logic          held;
    int            sent;
    int            rcvd;
    int            cyc;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        step();
        step();

        // Reset state, observed while reset is still held
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_cnt", bubble_cnt, 0);
        check("rst_instr", out_instr, 0);
        check("rst_ra", out_regaddr, 0);
        check("rst_pc4", out_pc4, 0);
        check("rst_payload", out_payload, 0);
        $display("reset: valid=%0b ready=%0b cnt=%0d", out_valid, in_ready, bubble_cnt);

        // Four back-to-back entries with out_ready=1
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), RA_W'(i), 32'(i * 4), PAYLOAD_W'(i * 100));
            step();
            check("b2b_valid", out_valid, 1);
            check("b2b_instr", out_instr, i);
            check("b2b_ra", out_regaddr, i);
            check("b2b_pc4", out_pc4, i * 4);
            check("b2b_payload", out_payload, i * 100);
            check("b2b_ready", in_ready, 1);
            $display("b2b: entry %0d out_instr=%0h ra=%0d", i, out_instr, out_regaddr);
        end
        check("b2b_cnt", bubble_cnt, 1);
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        step();
        check("b2b_drain", out_valid, 0);

        // Fill with out_ready=0: A then B lands in skid
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd10, 32'h100, 96'hAAA);
        step();
        drive(1'b1, 32'hB, 5'd11, 32'h104, 96'hBBB);
        step();
        check("skid_ready", in_ready, 0);
        check("skid_outA", out_instr, 32'hA);
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        step();
        check("skid_stableA", out_instr, 32'hA);
        check("skid_stable_pl", out_payload, 96'hAAA);
        check("skid_stable_ra", out_regaddr, 10);
        out_ready = 1'b1;
        step();
        check("skid_outB", out_instr, 32'hB);
        check("skid_raB", out_regaddr, 11);
        check("skid_ready_back", in_ready, 1);
        step();
        check("skid_empty", out_valid, 0);
        $display("skid: A then B delivered, ready=%0b", in_ready);

        // Flush while in SKID with a new entry C offered
        out_ready = 1'b0;
        drive(1'b1, 32'h21, 5'd1, 32'h200, 96'h1);
        step();
        drive(1'b1, 32'h22, 5'd2, 32'h204, 96'h2);
        step();
        check("fl_pre_skid", in_ready, 0);
        drive(1'b1, 32'hC, 5'd12, 32'h300, 96'hCCC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_instr", out_instr, 0);
        check("fl_ra", out_regaddr, 0);
        check("fl_ready", in_ready, 1);
        check("fl_pc4", out_pc4, 0);
        check("fl_payload", out_payload, 0);
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_C", out_valid, 0);
        end
        $display("flush: stage empty, C dropped");

        // Idle bubble counting and saturation at 15
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("idle_cnt", bubble_cnt, (k > 15) ? 15 : k);
            check("idle_ra", out_regaddr, 0);
            check("idle_instr", out_instr, 0);
        end
        $display("idle: bubble_cnt=%0d", bubble_cnt);

        // Reset while FULL holding D
        out_ready = 1'b0;
        drive(1'b1, 32'hD, 5'd7, 32'h400, 96'hDDD);
        step();
        check("rstD_held", out_regaddr, 7);
        reset = 1'b1;
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        step();
        check("rstD_valid", out_valid, 0);
        check("rstD_ra", out_regaddr, 0);
        check("rstD_cnt", bubble_cnt, 0);
        check("rstD_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("rstD_lost", out_valid, 0);
        $display("reset-in-full: D discarded");

        // Randomized traffic against a FIFO scoreboard
        do_reset();
        sent = 0;
        rcvd = 0;
        held = 1'b0;
        cyc  = 0;
        while ((rcvd < 1000) && (cyc < 20000)) begin
            if (held) begin
                check("rnd_stable", {out_valid, out_instr, out_regaddr, out_pc4, out_payload},
                      {1'b1, held_e});
            end
            if (!out_valid) begin
                check("rnd_bubble", {out_instr, out_regaddr}, 0);
            end
            out_ready = ($urandom_range(1, 0) == 1);
            if ((sent < 1000) && ($urandom_range(1, 0) == 1)) begin
                drive(1'b1, $urandom, RA_W'($urandom), $urandom,
                      {$urandom, $urandom, $urandom});
            end else begin
                drive(1'b0, 32'd0, '0, 32'd0, '0);
            end
            held   = out_valid && !out_ready;
            held_e = {out_instr, out_regaddr, out_pc4, out_payload};
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_extra", 1, 0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("rnd_data", {out_instr, out_regaddr, out_pc4, out_payload}, exp_e);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({in_instr, in_regaddr, in_pc4, in_payload});
                sent++;
            end
            step();
            cyc++;
        end
        drive(1'b0, 32'd0, '0, 32'd0, '0);
        check("rnd_timeout", cyc < 20000, 1);
        check("rnd_sent", sent, 1000);
        check("rnd_rcvd", rcvd, 1000);
        check("rnd_leftover", sb_q.size(), 0);
        $display("random: sent=%0d received=%0d cycles=%0d", sent, rcvd, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mw_pipe_stage.md
Name: mw_pipe_stage

Overview:
- Parametrised successor to the fixed M→W pipeline latch: a one-cycle pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush, and bubble accounting.
- Sits between the memory stage and the writeback stage. It lets writeback back-pressure memory without a combinational ready path.
- It also guarantees that bubbles present a null register write (regaddr 0) to the forwarding and hazard logic.

Parameters:
- PAYLOAD_W, 96, width of the opaque data payload (ALU result, DM read data, MD result concatenated).
- RA_W, 5, destination register address width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_instr  input  32  instruction word
- in_regaddr  input  RA_W  destination register (0 = no write)
- in_pc4  input  32  PC+4
- in_payload  input  PAYLOAD_W  data payload
- flush  input  1  synchronous kill of all held entries
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  instruction word; 0 when out_valid=0
- out_regaddr  output  RA_W  destination register; 0 when out_valid=0
- out_pc4  output  32  PC+4 of the head entry
- out_payload  output  PAYLOAD_W  payload of the head entry
- bubble_cnt  output  CNT_W  count of cycles with out_valid=0

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - out_valid=0, in_ready=1, bubble_cnt=0.
  - All data outputs and both buffer entries become 0.
  - Reset mid-operation discards all held entries.
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready. Both are sampled at the posedge.
- Storage: a MAIN entry drives the outputs; a SKID entry holds overflow. in_ready is the registered value of ~skid_full.
- States and transitions (F = flush, I = input transfer, O = output transfer):
  - EMPTY: I → FULL; otherwise stay EMPTY.
  - FULL: I & O → FULL (MAIN takes the new entry); I & ~O → SKID (new entry into SKID); ~I & O → EMPTY; otherwise stay FULL.
  - SKID: in_ready=0, so no input is accepted. O → FULL (SKID moves to MAIN, SKID cleared); otherwise stay SKID.
- Latency: 1 cycle from input transfer into EMPTY to out_valid=1.
- Ordering: strict FIFO; no entry is duplicated or dropped except by flush or reset.
- Flush:
  - Has priority over any input or output transfer in the same cycle.
  - Next state is EMPTY with in_ready=1, and both entries are zeroed.
  - An in_valid in the flush cycle is dropped.
  - An output transfer in the flush cycle still counts as consumed by downstream.
- Bubble outputs:
  - When out_valid=0, out_instr=0 and out_regaddr=0 (forced, not merely held).
  - out_pc4 and out_payload are 0 when EMPTY.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- bubble_cnt: increments each non-reset cycle in which out_valid=0. It saturates at 2^CNT_W-1 and never wraps.
- in_regaddr=0 entries are legal and carried through unchanged.

Test Plan:
- Reset, then 4 back-to-back entries (instr 0x1..0x4, regaddr 1..4, out_ready=1) → each appears 1 cycle after accept, in order; in_ready stays 1; bubble_cnt=1 (the first cycle before any entry arrives).
- Fill with out_ready=0: accept A, B → state SKID, in_ready=0, out shows A stable. Raise out_ready → A, then B, each for one cycle; in_ready returns to 1 one cycle after A leaves.
- Flush in SKID with in_valid=1 (entry C) → next cycle out_valid=0, out_instr=0, out_regaddr=0, in_ready=1; C is never output.
- Idle with out_ready=1 → out_regaddr=0 and out_instr=0 every cycle; bubble_cnt increments by 1 per cycle. With CNT_W=4, it sticks at 15 after 15 bubble cycles.
- Assert reset while in FULL holding entry D (regaddr 7) → next cycle out_valid=0, out_regaddr=0, bubble_cnt=0, in_ready=1; D is lost.
- Random in_valid/out_ready at 50% each, 1000 entries with PAYLOAD_W=96 → scoreboard shows exact in-order delivery, no loss, and no duplication.
